// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read at a time, results buffered
// in a small prefetch queue; redirects flush the queue and drain stale responses.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

  state_e        state_q;
  logic          imem_req_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   txn_pc_q;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push, pop;
  logic [31:0]   redirect_al;

  assign redirect_al = {redirect_pc[31:2], 2'b00};
  // A response is only kept if it belongs to the current fetch stream.
  assign push        = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pop         = (count_q != '0) && out_ready && !redirect;
  assign count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);

  assign imem_req  = imem_req_q;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      imem_req_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      txn_pc_q   <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_al;
          end else if (count_q < FULL) begin
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc_q <= redirect_al;
            imem_req_q <= 1'b0;
            state_q    <= imem_gnt ? DRAIN : IDLE;
          end else if (imem_gnt) begin
            txn_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            imem_req_q <= 1'b0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc_q <= redirect_al;
            state_q    <= imem_rvalid ? IDLE : DRAIN;
          end else if (imem_rvalid) begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (redirect) fetch_pc_q <= redirect_al;
          // The stale response ends the drain even if another redirect lands with it.
          if (imem_rvalid) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= txn_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the pipelined core; sits directly upstream of decode/datapath.
- Issues word reads to instruction memory over a req/gnt/rvalid handshake, one outstanding transaction at a time.
- Buffers returned {pc, instruction} pairs in a small prefetch queue and presents them downstream with valid/ready.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address, bits[1:0] always 00
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid; at least 1 cycle after gnt
imem_rdata  input  32  returned instruction
out_valid  output  1  queue head valid for decode
out_instr  output  32  head instruction
out_pc  output  32  head PC
out_ready  input  1  decode consumes head when out_valid&&out_ready
redirect  input  1  branch/jump taken; restart fetch
redirect_pc  input  32  new fetch address; bits[1:0] ignored, forced 00

Behaviour:
- Reset (async): fetch_pc=RESET_PC; queue empty; state IDLE; imem_req=0; out_valid=0; out_instr=0; out_pc=0; imem_addr=RESET_PC.
- States: IDLE (no transaction), REQ (imem_req high, waiting gnt), WAIT (granted, awaiting rvalid), DRAIN (awaiting a stale rvalid to discard).
- IDLE->REQ when count+outstanding<DEPTH and !redirect; imem_req asserts the next cycle.
- REQ: imem_req=1, imem_addr=fetch_pc, held stable until gnt. On gnt: fetch_pc+=4 (mod 2^32; 0xFFFF_FFFC wraps to 0), ->WAIT. No request withdrawal except on redirect.
- WAIT: on rvalid push {pc_of_txn, imem_rdata} to tail, ->IDLE. The next request is issued no earlier than the following cycle.
- Min latency: gnt in cycle N, rvalid in cycle N+1 -> out_valid in cycle N+2 if queue was empty.
- Queue: out_valid = !empty; out_instr/out_pc come directly from the head register. Pop on out_valid&&out_ready; push and pop in the same cycle are allowed.
- Space reservation: a request is issued only if a slot is free including the outstanding transaction, so a push never hits a full queue.
- Redirect has highest priority. In the redirect cycle:
  - queue cleared; out_valid=0 from the next cycle.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - a pop in the same cycle counts as consumed; it is harmless.
- Redirect while in REQ without gnt this cycle: request dropped; imem_req=0 next cycle; ->IDLE.
- Redirect while in WAIT, or REQ with gnt the same cycle: ->DRAIN.
- Redirect in WAIT with rvalid the same cycle: response discarded; ->IDLE.
- DRAIN: imem_req=0. On rvalid: discard data, ->IDLE. A further redirect in DRAIN updates fetch_pc only and stays in DRAIN.
- rvalid in IDLE or REQ (no outstanding transaction): ignored.
- Reset mid-transaction: all state cleared immediately. The memory side must also be reset; no drain is performed.
- Back-pressure: out_ready=0 indefinitely -> queue fills to DEPTH, then imem_req stays 0. No data is lost or reordered.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC. Instructions match memory in order. First out_valid 3 cycles after reset deassert.
- out_ready=0 for 20 cycles -> exactly 4 entries buffered (pcs 0x0-0xC); imem_req low after 4th gnt. Releasing out_ready drains in order and fetch resumes at 0x10.
- Redirect to 0x0000_0103 while in WAIT, stale rvalid 3 cycles later with 0xDEADBEEF -> stale data never appears. Next imem_addr=0x0000_0100; first out_pc=0x100.
- Redirect in REQ with gnt=0 (imem_addr=0x20) -> imem_req drops next cycle, no DRAIN. Then imem_addr=redirect target and the sequence continues.
- Redirect to 0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Async reset pulse asserted mid-WAIT with a queue holding 2 entries -> out_valid and imem_req drop immediately. After release, fetch restarts at RESET_PC.
